free_list_mp: RTL and testbench

Multi-port circular-queue physical-register free list for the R10K rename stage. It replaces the single-port LIFO with a FIFO ring of free physical tags. Dispatch can allocate up to ALLOC_WIDTH tags per cycle and retire can return up to FREE_WIDTH tags per cycle. Sits between the map table/dispatch logic (consumer) and the ROB retire path (producer).

---
 rtl/free_list_mp_pkg.sv | 23 ++
 rtl/free_list_mp_prefix_cnt.sv | 23 ++
 rtl/free_list_mp.sv | 148 ++++++++++++++
 tb/tb_free_list_mp.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/free_list_mp_pkg.sv
// Shared defaults and width helpers for the multi-port physical-register free list.
package free_list_mp_pkg;

    localparam int PHYS_REG_SZ = 64;
    localparam int N_AREGS     = 32;
    localparam int N_ALLOC     = 2;
    localparam int N_FREE      = 2;

    // Ring index width; a one-entry ring still gets a 1-bit pointer.
    function automatic int fl_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Count width must hold the value DEPTH itself.
    function automatic int fl_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int fl_tag_w(input int npregs);
        return (npregs > 1) ? $clog2(npregs) : 1;
    endfunction

endpackage

// File: rtl/free_list_mp_prefix_cnt.sv
// Prefix-contiguous enable filter: keeps lanes up to the first 0 and counts them.
module fl_prefix_cnt #(
    parameter int W  = 2,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  en,
    output logic [W-1:0]  mask,
    output logic [CW-1:0] cnt
);

    always_comb begin
        logic run;
        run  = 1'b1;
        mask = '0;
        cnt  = '0;
        for (int i = 0; i < W; i++) begin
            run     = run & en[i];
            mask[i] = run;
            cnt     = cnt + CW'(run);
        end
    end

endmodule

// File: rtl/free_list_mp.sv
// Circular-FIFO free list of physical tags with ALLOC_WIDTH allocate and FREE_WIDTH free lanes.
// Define FREE_LIST_RECOVER_EN to add recover_en/recover_head for mispredict rollback.
module free_list_mp
    import free_list_mp_pkg::*;
#(
    parameter int  NUM_PREGS   = PHYS_REG_SZ,
    parameter int  NUM_AREGS   = N_AREGS,
    parameter int  ALLOC_WIDTH = N_ALLOC,
    parameter int  FREE_WIDTH  = N_FREE,
    localparam int DEPTH       = NUM_PREGS - NUM_AREGS,
    localparam int TAG_W       = fl_tag_w(NUM_PREGS),
    localparam int PTR_W       = fl_ptr_w(DEPTH),
    localparam int CNT_W       = fl_cnt_w(DEPTH)
) (
    input  logic                                clk,
    input  logic                                reset,
`ifdef FREE_LIST_RECOVER_EN
    input  logic                                recover_en,
    input  logic [PTR_W-1:0]                    recover_head,
`endif
    input  logic [ALLOC_WIDTH-1:0]              alloc_en,
    output logic [ALLOC_WIDTH-1:0][TAG_W-1:0]   alloc_tag,
    output logic [ALLOC_WIDTH-1:0]              alloc_valid,
    input  logic [FREE_WIDTH-1:0]               free_en,
    input  logic [FREE_WIDTH-1:0][TAG_W-1:0]    free_tag,
    output logic [CNT_W-1:0]                    count,
    output logic                                empty,
    output logic                                full,
    output logic                                err,
    output logic [PTR_W-1:0]                    head_ptr
);

    localparam int SUM_W = CNT_W + 2;
    localparam int ACW   = $clog2(ALLOC_WIDTH + 1);
    localparam int FCW   = $clog2(FREE_WIDTH + 1);

    // Modulo-DEPTH advance by explicit compare-and-subtract; DEPTH need not be 2^n.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input logic [SUM_W-1:0] n);
        logic [SUM_W-1:0] s;
        s = SUM_W'(p) + n;
        if (s >= SUM_W'(DEPTH)) s = s - SUM_W'(DEPTH);
        return PTR_W'(s);
    endfunction

    logic [TAG_W-1:0] ring_q [DEPTH];
    logic [TAG_W-1:0] ring_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    logic [ALLOC_WIDTH-1:0] a_mask;
    logic [ACW-1:0]         a_cnt;
    logic [FREE_WIDTH-1:0]  f_mask;
    logic [FCW-1:0]         f_cnt;

    logic [CNT_W-1:0] a_req, f_req, n_a, n_f, room, rec_diff;
    logic             a_gap, f_gap, alloc_bad, free_bad;
    logic             rec_en;
    logic [PTR_W-1:0] rec_head;

`ifdef FREE_LIST_RECOVER_EN
    assign rec_en   = recover_en;
    assign rec_head = recover_head;
`else
    assign rec_en   = 1'b0;
    assign rec_head = '0;
`endif

    fl_prefix_cnt #(.W(ALLOC_WIDTH)) u_alloc_pfx (
        .en   (alloc_en),
        .mask (a_mask),
        .cnt  (a_cnt)
    );

    fl_prefix_cnt #(.W(FREE_WIDTH)) u_free_pfx (
        .en   (free_en),
        .mask (f_mask),
        .cnt  (f_cnt)
    );

    always_comb begin
        a_req     = CNT_W'(a_cnt);
        f_req     = CNT_W'(f_cnt);
        a_gap     = |(alloc_en & ~a_mask);
        f_gap     = |(free_en & ~f_mask);
        n_a       = '0;
        alloc_bad = 1'b0;
        // A rollback discards same-cycle allocations without flagging them.
        if (!rec_en) begin
            n_a       = (a_req > count_q) ? count_q : a_req;
            alloc_bad = a_gap || (a_req > count_q);
        end

        // Slots being allocated this edge may be refilled by the frees.
        room     = CNT_W'(DEPTH) - count_q + n_a;
        n_f      = (f_req > room) ? room : f_req;
        free_bad = f_gap || (f_req > room);

        ring_d = ring_q;
        for (int j = 0; j < FREE_WIDTH; j++) begin
            if (CNT_W'(j) < n_f) ring_d[ptr_add(tail_q, SUM_W'(j))] = free_tag[j];
        end

        tail_d   = ptr_add(tail_q, SUM_W'(n_f));
        head_d   = ptr_add(head_q, SUM_W'(n_a));
        count_d  = count_q - n_a + n_f;
        rec_diff = (tail_d >= rec_head) ? CNT_W'(tail_d - rec_head)
                                        : CNT_W'(DEPTH) - CNT_W'(rec_head - tail_d);
        if (rec_en) begin
            head_d  = rec_head;
            // head == tail is ambiguous; it means full unless the list was empty and stayed so.
            count_d = (rec_diff == '0 && (count_q != '0 || n_f != '0)) ? CNT_W'(DEPTH) : rec_diff;
        end

        err_d = err_q | alloc_bad | free_bad;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ring_q[i] <= TAG_W'(NUM_AREGS + i);
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CNT_W'(DEPTH);
            err_q   <= 1'b0;
        end else begin
            ring_q  <= ring_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            alloc_tag[i]   = ring_q[ptr_add(head_q, SUM_W'(i))];
            alloc_valid[i] = count_q > CNT_W'(i);
        end
    end

    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign err      = err_q;
    assign head_ptr = head_q;

endmodule

// File: tb/tb_free_list_mp.sv
// Free-list bench: directed test-plan cases plus random traffic against a tag-queue model.
module tb_free_list_mp;

    localparam int NP    = 64;
    localparam int NA    = 32;
    localparam int AW    = 2;
    localparam int FW    = 2;
    localparam int DEPTH = NP - NA;
    localparam int TW    = 6;
    localparam int PW    = 5;
    localparam int CW    = 6;

    logic                  clk;
    logic                  reset;
    logic [AW-1:0]         alloc_en;
    logic [AW-1:0][TW-1:0] alloc_tag;
    logic [AW-1:0]         alloc_valid;
    logic [FW-1:0]         free_en;
    logic [FW-1:0][TW-1:0] free_tag;
    logic [CW-1:0]         count;
    logic                  empty, full, err;
    logic [PW-1:0]         head_ptr;
`ifdef FREE_LIST_RECOVER_EN
    logic                  recover_en;
    logic [PW-1:0]         recover_head;
`endif

    free_list_mp dut (
        .clk          (clk),
        .reset        (reset),
`ifdef FREE_LIST_RECOVER_EN
        .recover_en   (recover_en),
        .recover_head (recover_head),
`endif
        .alloc_en     (alloc_en),
        .alloc_tag    (alloc_tag),
        .alloc_valid  (alloc_valid),
        .free_en      (free_en),
        .free_tag     (free_tag),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .err          (err),
        .head_ptr     (head_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the free list is just an ordered queue of tags.
    int q[$];
    int m_head;
    bit m_err;
    bit chk_on;
    int checks;
    int failures;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic lead_ones(input logic [3:0] v, input int w, output int n, output bit gap);
        bit run;
        run = 1;
        n   = 0;
        gap = 0;
        for (int i = 0; i < w; i++) begin
            if (run && v[i]) n++;
            else begin
                if (v[i]) gap = 1;
                run = 0;
            end
        end
    endtask

    task automatic model_step();
        int  na_req, nf_req, na, nf, room;
        bit  agap, fgap;
        if (reset) begin
            q.delete();
            for (int i = 0; i < DEPTH; i++) q.push_back(NA + i);
            m_head = 0;
            m_err  = 0;
            return;
        end
        lead_ones(4'(alloc_en), AW, na_req, agap);
        lead_ones(4'(free_en), FW, nf_req, fgap);
        na = (na_req < q.size()) ? na_req : q.size();
        if (agap || na_req > q.size()) m_err = 1;
        room = DEPTH - q.size() + na;
        nf = (nf_req < room) ? nf_req : room;
        if (fgap || nf_req > room) m_err = 1;
        repeat (na) void'(q.pop_front());
        for (int j = 0; j < nf; j++) q.push_back(int'(free_tag[j]));
        m_head = (m_head + na) % DEPTH;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("count", int'(count), q.size());
            chk("empty", int'(empty), int'(q.size() == 0));
            chk("full", int'(full), int'(q.size() == DEPTH));
            chk("err", int'(err), int'(m_err));
            chk("head_ptr", int'(head_ptr), m_head);
            for (int i = 0; i < AW; i++) begin
                chk("alloc_valid", int'(alloc_valid[i]), int'(q.size() > i));
                if (q.size() > i) chk("alloc_tag", int'(alloc_tag[i]), q[i]);
            end
        end
    end

    task automatic cyc(input logic [AW-1:0] a, input logic [FW-1:0] f, input int t0, input int t1);
        alloc_en    = a;
        free_en     = f;
        free_tag[0] = TW'(t0);
        free_tag[1] = TW'(t1);
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc('0, '0, 0, 0);
        cyc('0, '0, 0, 0);
        reset = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [FW-1:0] rf;
        checks   = 0;
        failures = 0;
        chk_on   = 0;
        reset    = 1'b1;
        alloc_en = '0;
        free_en  = '0;
        free_tag = '0;
`ifdef FREE_LIST_RECOVER_EN
        recover_en   = 1'b0;
        recover_head = '0;
`endif
        do_reset();
        chk_on = 1;
        chk("rst_count", int'(count), 32);
        chk("rst_full", int'(full), 1);
        chk("rst_empty", int'(empty), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_tag0", int'(alloc_tag[0]), 32);
        chk("rst_tag1", int'(alloc_tag[1]), 33);

        // Three 2-wide allocations.
        cyc(2'b11, '0, 0, 0);
        chk("a1_count", int'(count), 30);
        chk("a1_tag0", int'(alloc_tag[0]), 34);
        cyc(2'b11, '0, 0, 0);
        chk("a2_count", int'(count), 28);
        chk("a2_tag1", int'(alloc_tag[1]), 37);
        cyc(2'b11, '0, 0, 0);
        chk("a3_count", int'(count), 26);
        chk("a3_head", int'(head_ptr), 6);

        // Drain, then over-allocate.
        repeat (13) cyc(2'b11, '0, 0, 0);
        chk("drain_count", int'(count), 0);
        chk("drain_empty", int'(empty), 1);
        chk("drain_valid", int'(alloc_valid), 0);
        cyc(2'b01, '0, 0, 0);
        chk("under_err", int'(err), 1);
        chk("under_head", int'(head_ptr), 0);

        // Free 5, 9; then free+alloc in the same cycle.
        cyc('0, 2'b11, 5, 9);
        chk("fr_count", int'(count), 2);
        chk("fr_tag0", int'(alloc_tag[0]), 5);
        chk("fr_tag1", int'(alloc_tag[1]), 9);
        cyc(2'b01, 2'b01, 11, 0);
        chk("fa_count", int'(count), 2);
        chk("fa_tag0", int'(alloc_tag[0]), 9);
        chk("fa_tag1", int'(alloc_tag[1]), 11);
        cyc(2'b11, '0, 0, 0);
        chk("fa2_head", int'(head_ptr), 3);

        // Head wrap from index 31.
        do_reset();
        repeat (15) cyc(2'b11, '0, 0, 0);
        cyc(2'b01, '0, 0, 0);
        chk("wr_head", int'(head_ptr), 31);
        chk("wr_count", int'(count), 1);
        chk("wr_tag0", int'(alloc_tag[0]), 63);
        cyc(2'b01, 2'b01, 40, 0);
        chk("wr_head2", int'(head_ptr), 0);
        chk("wr_count2", int'(count), 1);
        chk("wr_tag0b", int'(alloc_tag[0]), 40);
        chk("wr_err", int'(err), 0);

        // Overflow from full.
        do_reset();
        cyc('0, 2'b01, 7, 0);
        chk("ov_err", int'(err), 1);
        chk("ov_count", int'(count), 32);
        chk("ov_tag0", int'(alloc_tag[0]), 32);
        chk("ov_tag1", int'(alloc_tag[1]), 33);

        // Random traffic with occasional resets.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            ra = AW'((1 << $urandom_range(0, AW)) - 1);
            if ($urandom_range(0, 9) == 0) ra = AW'($urandom);
            rf = FW'((1 << $urandom_range(0, FW)) - 1);
            if ($urandom_range(0, 9) == 0) rf = FW'($urandom);
            cyc(ra, rf, $urandom_range(0, NP - 1), $urandom_range(0, NP - 1));
        end

`ifdef FREE_LIST_RECOVER_EN
        chk_on = 0;
        do_reset();
        repeat (2) cyc(2'b11, '0, 0, 0);
        chk("rc_snap", int'(head_ptr), 4);
        repeat (3) cyc(2'b11, '0, 0, 0);
        chk("rc_pre_count", int'(count), 22);
        recover_en   = 1'b1;
        recover_head = PW'(4);
        cyc(2'b11, '0, 0, 0);
        recover_en   = 1'b0;
        chk("rc_head", int'(head_ptr), 4);
        chk("rc_count", int'(count), 28);
        chk("rc_tag0", int'(alloc_tag[0]), 36);
        chk("rc_tag1", int'(alloc_tag[1]), 37);
        chk("rc_err", int'(err), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
